// File: rtl/fpu_result_fifo.sv
// Result buffer behind the FPU output mux: classifies each captured IEEE-754
// single result and queues it in a first-word-fall-through FIFO with sticky error flags.
module fpu_result_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [2:0]    in_op,
  input  logic [31:0]   in_data,
  input  logic          in_great,
  input  logic          in_less,
  input  logic          in_equal,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [2:0]    out_op,
  output logic [2:0]    out_cmp,
  output logic [3:0]    out_class,
  output logic [AW:0]   count,
  output logic          err_ovf,
  output logic          err_op
);

  localparam logic [2:0]  OP_CMP  = 3'd4;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [31:0]   r_data  [DEPTH];
  logic [2:0]    r_op    [DEPTH];
  logic [2:0]    r_cmp   [DEPTH];
  logic [3:0]    r_class [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_err_ovf, r_err_op;

  logic          w_full, w_empty, w_legal, w_push, w_pop;
  logic [7:0]    w_exp;
  logic [22:0]   w_man;
  logic          w_e_ones, w_e_zero, w_m_zero;
  logic [3:0]    w_class;
  logic [2:0]    w_cmp;

  assign w_full   = (r_count == CNT_MAX);
  assign w_empty  = (r_count == '0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready = !w_full || out_ready;
  assign w_legal  = (in_op <= OP_CMP);
  assign w_push   = in_valid && in_ready && w_legal;
  assign w_pop    = !w_empty && out_ready;

  assign w_exp    = in_data[30:23];
  assign w_man    = in_data[22:0];
  assign w_e_ones = (w_exp == 8'hFF);
  assign w_e_zero = (w_exp == 8'h00);
  assign w_m_zero = (w_man == '0);

  // Compare results carry flags only; arithmetic results carry class only.
  always_comb begin
    w_class = '0;
    w_cmp   = '0;
    if (in_op == OP_CMP) begin
      w_cmp = {in_great, in_less, in_equal};
    end else begin
      w_class = {w_e_ones && !w_m_zero, w_e_ones && w_m_zero,
                 w_e_zero && w_m_zero,  w_e_zero && !w_m_zero};
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr]  <= in_data;
      r_op[r_wr_ptr]    <= in_op;
      r_cmp[r_wr_ptr]   <= w_cmp;
      r_class[r_wr_ptr] <= w_class;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
      r_err_op  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && !in_ready)            r_err_ovf <= 1'b1;
      if (in_valid && in_ready && !w_legal) r_err_op  <= 1'b1;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_data[r_rd_ptr];
  assign out_op    = w_empty ? '0 : r_op[r_rd_ptr];
  assign out_cmp   = w_empty ? '0 : r_cmp[r_rd_ptr];
  assign out_class = w_empty ? '0 : r_class[r_rd_ptr];
  assign count     = r_count;
  assign err_ovf   = r_err_ovf;
  assign err_op    = r_err_op;

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Randomized and directed bench for fpu_result_fifo against a queue-based model.
module tb_fpu_result_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_great, in_less, in_equal, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic        in_ready, out_valid, err_ovf, err_op;
  logic [31:0] out_data;
  logic [2:0]  out_op, out_cmp;
  logic [3:0]  out_class;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_data(in_data),
    .in_great(in_great), .in_less(in_less), .in_equal(in_equal), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .out_cmp(out_cmp), .out_class(out_class), .count(count), .err_ovf(err_ovf),
    .err_op(err_op)
  );

  always #5 clk = ~clk;

  // Model: queue of {data, op, cmp, class}, plus sticky flags.
  logic [41:0] q[$];
  logic        m_ovf, m_eop;

  function automatic logic [3:0] cls(input logic [2:0] op, input logic [31:0] d);
    int e, m;
    e = int'(d[30:23]);
    m = int'(d[22:0]);
    if (op == 3'd4) return 4'b0000;
    return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0, e == 0 && m != 0};
  endfunction

  function automatic logic [48:0] exp_vec();
    logic [41:0] h;
    logic        rdy;
    h   = (q.size() == 0) ? 42'd0 : q[0];
    rdy = (q.size() != DEPTH) || out_ready;
    return {q.size() != 0, h, 3'(q.size()), m_ovf, m_eop, rdy};
  endfunction

  function automatic logic [48:0] dut_vec();
    return {out_valid, out_data, out_op, out_cmp, out_class, count, err_ovf, err_op, in_ready};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d,
                       input logic [2:0] gle, input logic ordy);
    in_valid = v; in_op = op; in_data = d;
    {in_great, in_less, in_equal} = gle; out_ready = ordy;
    #1;
  endtask

  // Advance one clock, applying the same inputs to the model.
  task automatic step();
    logic rdy, pop, push;
    logic [41:0] ent;
    rdy  = (q.size() != DEPTH) || out_ready;
    pop  = (q.size() != 0) && out_ready;
    push = in_valid && rdy && (in_op <= 3'd4);
    ent  = {in_data, in_op, (in_op == 3'd4) ? {in_great, in_less, in_equal} : 3'b000,
            cls(in_op, in_data)};
    @(posedge clk);
    if (rst) begin
      q.delete(); m_ovf = 1'b0; m_eop = 1'b0;
    end else begin
      if (in_valid && !rdy) m_ovf = 1'b1;
      if (in_valid && rdy && in_op > 3'd4) m_eop = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ent);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 49'h1) begin
      n_bad++; $display("FAIL reset: got %h want %h", dut_vec(), 49'h1);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    drive(1, 3'd0, 32'h3F800000, 3'b111, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({out_valid, out_data, out_op, out_cmp, out_class, count} !==
        {1'b1, 32'h3F800000, 3'd0, 3'b000, 4'b0000, 3'd1}) begin
      n_bad++; $display("FAIL basic_push: got %h want %h", dut_vec(), exp_vec());
    end
    drive(0, 0, 0, 0, 1);
    step();
    n_cmp++;
    if ({out_valid, out_data, out_op, out_cmp, out_class, count} !== 46'd0) begin
      n_bad++; $display("FAIL basic_pop: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_classes();
    logic [31:0] d[4] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h0};
    logic [3:0]  c[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0000};
    logic [2:0]  g[4] = '{3'b000, 3'b000, 3'b000, 3'b100};
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i + 1), d[i], i == 3 ? 3'b100 : 3'b011, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      n_cmp++;
      if ({out_data, out_op, out_cmp, out_class} !== {d[i], 3'(i + 1), g[i], c[i]}) begin
        n_bad++;
        $display("FAIL class_%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, out_data, out_op,
                 out_cmp, out_class, d[i], i + 1, g[i], c[i]);
      end
      step();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd2, 32'h40000000 + 32'(i), 0, 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ovf_fill_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      step();
    end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({count, in_ready, err_ovf} !== {3'd4, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL ovf_state: got cnt %0d rdy %b ovf %b want 4 0 1",
                        count, in_ready, err_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      n_cmp++;
      if (out_data !== 32'h40000000 + 32'(i) || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ovf_drain_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; drive(0, 0, 0, 0, 0); step(); rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 3'd0, 32'h100 + 32'(i), 0, 0); step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'd1, 32'h100 + 32'(i + DEPTH), 0, 1);
      n_cmp++;
      if ({out_data, count, in_ready, err_ovf} !== {32'h100 + 32'(i), 3'd4, 1'b1, 1'b0} ||
          dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL b2b_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      step();
    end
  endtask

  task automatic test_illegal_op();
    rst = 1'b1; drive(0, 0, 0, 0, 0); step(); rst = 1'b0;
    drive(1, 3'd6, 32'h12345678, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({count, out_valid, err_op, err_ovf} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL illegal_op: got %h want %h", dut_vec(), exp_vec());
    end
    drive(1, 3'd0, 32'h00000001, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({out_class, count, err_op} !== {4'b0001, 3'd1, 1'b1}) begin
      n_bad++; $display("FAIL denorm: got class %b cnt %0d eop %b want 0001 1 1",
                        out_class, count, err_op);
    end
  endtask

  task automatic test_reset_midflight();
    rst = 1'b1; drive(0, 0, 0, 0, 0); step(); rst = 1'b0;
    drive(1, 3'd7, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd3, 32'h55 + 32'(i), 0, 0); step();
    end
    rst = 1'b1;
    drive(1, 3'd0, 32'hABCD, 0, 1); step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({count, out_valid, err_ovf, err_op, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL rst_mid: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       d = {1'($urandom), 8'h00, 23'($urandom_range(0, 1) ? $urandom : 0)};
        1:       d = {1'($urandom), 8'hFF, 23'($urandom_range(0, 1) ? $urandom : 0)};
        default: d = $urandom;
      endcase
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
            : 3'($urandom_range(0, 4)), d, 3'($urandom), $urandom_range(0, 2) == 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_ovf = 1'b0; m_eop = 1'b0;
    test_reset();
    test_basic();
    test_classes();
    test_overflow();
    test_back_to_back();
    test_illegal_op();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
